// File: rtl/rr_stream_mux.sv
// Round-robin N:1 stream multiplexer with a single registered output stage.
// Define RR_STREAM_MUX_LOCK_EN to hold the grant on one channel until in_last.
module rr_stream_mux #(
   parameter  int NUM_CH = 4,
   parameter  int WIDTH  = 8,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       in_last,
   output logic [NUM_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic [CH_W-1:0]         out_ch
);

   logic [WIDTH-1:0] ch_data [NUM_CH];

   logic [CH_W-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [CH_W-1:0]  out_ch_q, out_ch_d;

   logic             load_en;
   logic             rr_vld;
   logic [CH_W-1:0]  rr_idx;
   logic             gnt_vld;
   logic [CH_W-1:0]  gnt_idx;
   logic             xfer;

`ifdef RR_STREAM_MUX_LOCK_EN
   logic             lock_q, lock_d;
   logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // Channel index idx+off, modulo NUM_CH; idx is always below NUM_CH.
   function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] idx, input int off);
      int sum;
      sum = int'(idx) + off;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      return CH_W'(sum);
   endfunction

   assign load_en = !out_valid_q || out_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rr_vld = 1'b0;
      rr_idx = ptr_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rr_vld && in_valid[wrap_add(ptr_q, i)]) begin
            rr_vld = 1'b1;
            rr_idx = wrap_add(ptr_q, i);
         end
      end
   end

`ifdef RR_STREAM_MUX_LOCK_EN
   always_comb begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
      if (lock_q) begin
         gnt_vld = in_valid[lock_ch_q];
         gnt_idx = lock_ch_q;
      end
   end
`else
   assign gnt_vld = rr_vld;
   assign gnt_idx = rr_idx;
`endif

   // Ready is withheld during reset even though the empty output stage would accept.
   assign xfer = gnt_vld && load_en && !rst;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready[i] = xfer && (gnt_idx == CH_W'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
`ifdef RR_STREAM_MUX_LOCK_EN
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
`endif
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = ch_data[gnt_idx];
         out_last_d  = in_last[gnt_idx];
         out_ch_d    = gnt_idx;
`ifdef RR_STREAM_MUX_LOCK_EN
         lock_d      = !in_last[gnt_idx];
         lock_ch_d   = gnt_idx;
         if (in_last[gnt_idx]) ptr_d = wrap_add(gnt_idx, 1);
`else
         ptr_d       = wrap_add(gnt_idx, 1);
`endif
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
`ifdef RR_STREAM_MUX_LOCK_EN
         lock_q      <= 1'b0;
         lock_ch_q   <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
`ifdef RR_STREAM_MUX_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed self-checking bench for rr_stream_mux (NUM_CH=4, WIDTH=8).
// Expected lock behaviour follows RR_STREAM_MUX_LOCK_EN when defined.
module tb_rr_stream_mux;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;
   localparam int CH_W   = 2;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [NUM_CH*WIDTH-1:0] in_data  = '0;
   logic [NUM_CH-1:0]       in_valid = '0;
   logic [NUM_CH-1:0]       in_last  = '0;
   logic [NUM_CH-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic                    out_last;
   logic [CH_W-1:0]         out_ch;

   int n_cmp = 0;
   int n_err = 0;

   rr_stream_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_ch    (out_ch)
   );

   always #5 clk = ~clk;

   // Returns 1 ns after the rising edge so outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
      in_data[ch*WIDTH +: WIDTH] = d;
   endtask

   task automatic test_reset();
      in_valid  = 4'hF;
      out_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_last, out_ch, out_data} !== 12'h000) begin
         $display("FAIL reset_outputs: got v=%b l=%b ch=%0d d=%h, want all 0", out_valid, out_last, out_ch, out_data);
         n_err++;
      end
      n_cmp++;
      if (in_ready !== 4'b0000) begin
         $display("FAIL reset_ready: got %b, want 0000", in_ready);
         n_err++;
      end
      tick();
      tick();
      n_cmp++;
      if ({out_valid, in_ready} !== 5'b0) begin
         $display("FAIL reset_held: got v=%b rdy=%b, want 0/0000", out_valid, in_ready);
         n_err++;
      end
      in_valid = '0;
      rst      = 1'b0;
      #1;
   endtask

   task automatic test_round_robin();
      logic [NUM_CH-1:0] exp_rdy;
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 8'hA0 + 8'(c));
      in_valid  = 4'hF;
      out_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         exp_rdy = 4'b0001 << (k % 4);
         n_cmp++;
         if (in_ready !== exp_rdy) begin
            $display("FAIL rr_ready[%0d]: got %b, want %b", k, in_ready, exp_rdy);
            n_err++;
         end
         tick();
         n_cmp++;
         if ({out_valid, out_ch, out_data} !== {1'b1, 2'(k % 4), 8'hA0 + 8'(k % 4)}) begin
            $display("FAIL rr_beat[%0d]: got v=%b ch=%0d d=%h, want 1/%0d/%h", k, out_valid, out_ch, out_data, k % 4, 8'hA0 + 8'(k % 4));
            n_err++;
         end
      end
      in_valid = '0;
      tick();
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b0, 2'd0, 8'hA0}) begin
         $display("FAIL rr_drain: got v=%b ch=%0d d=%h, want 0/0/a0", out_valid, out_ch, out_data);
         n_err++;
      end
   endtask

   task automatic test_backpressure();
      set_ch(2, 8'h55);
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0100) begin
         $display("FAIL bp_first_ready: got %b, want 0100", in_ready);
         n_err++;
      end
      tick();
      set_ch(2, 8'h66);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({out_valid, out_ch, out_data, in_ready} !== {1'b1, 2'd2, 8'h55, 4'b0000}) begin
            $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h rdy=%b, want 1/2/55/0000", i, out_valid, out_ch, out_data, in_ready);
            n_err++;
         end
         if (i < 2) tick();
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0100) begin
         $display("FAIL bp_release_ready: got %b, want 0100", in_ready);
         n_err++;
      end
      tick();
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'h66}) begin
         $display("FAIL bp_reload: got v=%b ch=%0d d=%h, want 1/2/66", out_valid, out_ch, out_data);
         n_err++;
      end
      in_valid = '0;
      tick();
      n_cmp++;
      if ({out_valid, out_data} !== {1'b0, 8'h66}) begin
         $display("FAIL bp_drain: got v=%b d=%h, want 0/66", out_valid, out_data);
         n_err++;
      end
   endtask

   task automatic test_sparse();
      set_ch(3, 8'h3C);
      set_ch(1, 8'h1C);
      set_ch(0, 8'hC0);
      in_valid = 4'b1000;
      #1;
      n_cmp++;
      if (in_ready !== 4'b1000) begin
         $display("FAIL sparse_rdy3: got %b, want 1000", in_ready);
         n_err++;
      end
      tick();
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'h3C}) begin
         $display("FAIL sparse_ch3: got v=%b ch=%0d d=%h, want 1/3/3c", out_valid, out_ch, out_data);
         n_err++;
      end
      in_valid = 4'b0010;
      #1;
      tick();
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h1C}) begin
         $display("FAIL sparse_ch1: got v=%b ch=%0d d=%h, want 1/1/1c", out_valid, out_ch, out_data);
         n_err++;
      end
      // Pointer now 2: ch3 wins first, then the search wraps to ch0.
      in_valid = 4'b1001;
      #1;
      n_cmp++;
      if (in_ready !== 4'b1000) begin
         $display("FAIL sparse_from_ptr2: got %b, want 1000", in_ready);
         n_err++;
      end
      tick();
      n_cmp++;
      if (in_ready !== 4'b0001) begin
         $display("FAIL sparse_wrap_ready: got %b, want 0001", in_ready);
         n_err++;
      end
      tick();
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'hC0}) begin
         $display("FAIL sparse_wrap_beat: got v=%b ch=%0d d=%h, want 1/0/c0", out_valid, out_ch, out_data);
         n_err++;
      end
      in_valid = '0;
   endtask

   task automatic test_idle();
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({out_valid, in_ready, out_data} !== {1'b0, 4'b0000, 8'hC0}) begin
            $display("FAIL idle[%0d]: got v=%b rdy=%b d=%h, want 0/0000/c0", i, out_valid, in_ready, out_data);
            n_err++;
         end
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      set_ch(2, 8'h77);
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      tick();
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'h77}) begin
         $display("FAIL mid_loaded: got v=%b ch=%0d d=%h, want 1/2/77", out_valid, out_ch, out_data);
         n_err++;
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_last, out_ch, out_data, in_ready} !== 16'h0000) begin
         $display("FAIL mid_async_reset: got v=%b l=%b ch=%0d d=%h rdy=%b, want all 0", out_valid, out_last, out_ch, out_data, in_ready);
         n_err++;
      end
      in_valid  = 4'hF;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, in_ready} !== {1'b0, 4'b0001}) begin
         $display("FAIL mid_first_grant: got v=%b rdy=%b, want 0/0001", out_valid, in_ready);
         n_err++;
      end
      in_valid = '0;
      #1;
   endtask

   task automatic test_lock();
      logic [CH_W-1:0]  exp_ch   [4];
      logic             exp_last [4];
      logic [WIDTH-1:0] exp_data [4];
      int               ch0_sent;
      logic             gave0;
`ifdef RR_STREAM_MUX_LOCK_EN
      exp_ch   = '{2'd0, 2'd0, 2'd0, 2'd1};
      exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_data = '{8'h10, 8'h11, 8'h12, 8'h21};
`else
      exp_ch   = '{2'd0, 2'd1, 2'd0, 2'd1};
      exp_last = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_data = '{8'h10, 8'h21, 8'h11, 8'h21};
`endif
      ch0_sent  = 0;
      set_ch(1, 8'h21);
      in_last   = 4'b0010;
      in_valid  = 4'b0011;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_ch(0, 8'h10 + 8'(ch0_sent));
         in_last[0] = (ch0_sent == 2);
         #1;
         gave0 = in_ready[0];
         tick();
         n_cmp++;
         if ({out_ch, out_last, out_data} !== {exp_ch[k], exp_last[k], exp_data[k]}) begin
            $display("FAIL lock_beat[%0d]: got ch=%0d l=%b d=%h, want %0d/%b/%h", k, out_ch, out_last, out_data, exp_ch[k], exp_last[k], exp_data[k]);
            n_err++;
         end
         if (gave0) ch0_sent++;
      end
      in_valid = '0;
      in_last  = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_backpressure();
      test_sparse();
      test_idle();
      test_reset_midstream();
      test_lock();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
